// File: rtl/balsa_pull_source.sv
// balsa_pull_source: passive end of a Balsa four-phase pull channel.
// A synchronous valid/ready producer fills a small FIFO. Each pull request
// on p_0r is answered with the oldest buffered word on p_0d/p_0a.
// Optional build macro BALSA_PULL_SYNC_EN adds a two-flop synchronizer on
// p_0r for an initiator that runs asynchronously to clk.
module balsa_pull_source #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     p_0r,
  output logic                     p_0a,
  output logic [WIDTH-1:0]         p_0d,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic req_i;
  logic push;
  logic pop;
  logic empty;

`ifdef BALSA_PULL_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer bringing the asynchronous request into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= p_0r;
      sync2_q <= sync1_q;
    end
  end

  assign req_i = sync2_q;
`else
  assign req_i = p_0r;
`endif

  assign push  = s_valid && ready_q;
  assign empty = (count_q == '0);

  // Handshake next-state: entering ACK pops the FIFO head into the data register.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (!empty) begin
            state_d = ST_ACK;
            pop     = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (!empty) begin
          state_d = ST_ACK;
          pop     = 1'b1;
        end
      end
      ST_ACK: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping and registered output values.
  always_comb begin
    ack_d   = (state_d == ST_ACK);
    data_d  = data_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ready_d = (count_d != CW'(DEPTH));
    if (pop) begin
      data_d = mem_q[rptr_q];
      rptr_d = rptr_q + AW'(1);
    end
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
  end

  // State, pointers, count and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      count_q <= count_d;
      ready_q <= ready_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= s_data;
    end
  end

  assign s_ready = ready_q;
  assign p_0a    = ack_q;
  assign p_0d    = data_q;
  assign count   = count_q;

endmodule

// File: doc/balsa_pull_source.md
# balsa_pull_source

Clocked responder for the passive end of a Balsa four-phase pull channel (`_0r` / `_0a` / `_0d`). It supplies words to an asynchronous handshake-component initiator, such as the `i1`/`i2` input ports of a Balsa wrapper. Words enter from a synchronous valid/ready producer and are buffered in a small FIFO. Each pull request is answered with the oldest buffered word.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 4, FIFO depth in words; must be a power of two, ≥ 2.

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `s_valid`  input  1  producer offers `s_data`.
- `s_ready`  output  1  FIFO can accept; equals `!full`.
- `s_data`  input  `WIDTH`  producer word.
- `p_0r`  input  1  pull request from the initiator.
- `p_0a`  output  1  acknowledge; `p_0d` is valid while it is high.
- `p_0d`  output  `WIDTH`  pulled data word, registered.
- `count`  output  `$clog2(DEPTH)+1`  number of words currently buffered.

## Operation
- Push: a word is written when `s_valid && s_ready` at a clock edge.
- `s_ready` depends only on the registered `full` flag. There is no combinational path from the pull side, so a pop at a full FIFO does not allow a push in the same cycle.
- Handshake FSM, driven by the request signal `req_i` (see Configuration). Each state drives the acknowledge as stated:
  - IDLE (`p_0a`=0): on `req_i`=1 with FIFO non-empty, go to ACK. On `req_i`=1 with FIFO empty, go to WAIT.
  - WAIT (`p_0a`=0): when the FIFO becomes non-empty, go to ACK. If `req_i` drops (protocol violation), go to IDLE with no pop.
  - ACK (`p_0a`=1): on `req_i`=0, go to IDLE and drop `p_0a`.
- Entry to ACK loads the FIFO head into `p_0d`, pops it (`count` decrements) and raises `p_0a`, all in the same edge.
- `p_0d` holds its value until the next entry to ACK. Data therefore stays stable through the whole return-to-zero phase and beyond.
- Push and pop in the same edge: `count` is unchanged, and both pointers advance with wrap at `DEPTH`.
- There is no bypass: a word pushed at edge k is visible to the FSM at edge k+1.
- Reset, including mid-handshake:
  - `p_0a`=0, `p_0d`=0, `count`=0, FIFO pointers=0, FSM=IDLE.
  - `s_ready` reads 1 once reset is released.
  - A request still high after reset release is treated as a new request.

## Timing
- Edge numbering below: edge 1 is the first rising edge at which `p_0r`=1 is sampled.
- Request-to-acknowledge latency with a non-empty FIFO:
  - 1 edge without the synchronizer (`p_0a` high after edge 1).
  - 3 edges with it (`p_0a` high after edge 3).
- Request-to-acknowledge latency with an empty FIFO: 1 edge, or 3 with the synchronizer, after the edge at which the FIFO first holds a word.
- Release: `p_0a` falls 1 edge (or 3 with the synchronizer) after `p_0r` is sampled low.
- Minimum full four-phase cycle with the synchronizer: 6 clock cycles.
- `count` and `s_ready` update on the same edge as the push or pop that changes them.

## Configuration
- `BALSA_PULL_SYNC_EN` defined: `p_0r` passes through a two-flop synchronizer, reset to 0, to form `req_i`. Use this when the initiator is asynchronous to `clk`.
- `BALSA_PULL_SYNC_EN` undefined: `req_i` = `p_0r` directly. `p_0r` must then be synchronous to `clk`.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 (`WIDTH`=8, `DEPTH`=4), then three full pull handshakes:
  - `p_0d` = 0x11, 0x22, 0x33 in order.
  - `count` steps 3 → 2 → 1 → 0.
  - Ack latency is 1 edge without the macro and 3 edges with it.
- Raise `p_0r` with the FIFO empty, then push 0xA5 at edge k:
  - `p_0a` stays 0 until after edge k+1 (no macro).
  - `p_0d`=0xA5 when `p_0a` rises.
- Push 4 words:
  - `s_ready`=0 and `count`=4.
  - Holding `s_valid` high with 0xFF is not accepted.
  - A pull gives `count`=3, `s_ready`=1, and the first pushed word.
- Push and pop on the same edge with `count`=2: `count` stays 2 and order is preserved across pointer wrap. Continue with 10 words through the 4-entry FIFO.
- Assert `rst_n`=0 while `p_0a`=1:
  - `p_0a`, `p_0d` and `count` go to 0 immediately, without waiting for a clock edge.
  - After release with `p_0r` still high and an empty FIFO, the FSM waits in WAIT.
- Drop `p_0r` while in WAIT: FSM returns to IDLE, `count` is unchanged, and `p_0a` never pulses.
